ha_array_reduce_8x8: RTL and testbench



---
 rtl/ha_array_reduce_8x8.sv | 115 +++++++++++
 tb/tb_ha_array_reduce_8x8.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ha_array_reduce_8x8.sv
// ha_array_reduce_8x8
// Final reduction of the unsigned 8x8 half-adder-array generator output.
// The four row-pair arrays (carries b, sums/top carry t) are weighted and
// summed into a 16-bit product. The result is produced by a 2-stage pipeline
// with valid/ready handshakes on both sides.
//
// Parameters:
//   SATURATE  0: truncate the 17-bit sum to 16 bits; 1: clamp to 16'hFFFF
//   CNT_W     width of the accepted-transaction counter
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       upstream handshake
//   ha_array_k_b / _t         row pair k carries (7b) and sums/top carry (9b)
//   out_valid / out_ready     downstream handshake
//   product                   reduced product (registered)
//   ovf                       17-bit sum exceeded 16'hFFFF (registered)
//   txn_cnt                   number of accepted input transactions (wraps)

module ha_array_reduce_8x8 #(
    parameter int SATURATE = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       ha_array_0_b,
    input  logic [8:0]       ha_array_0_t,
    input  logic [6:0]       ha_array_1_b,
    input  logic [8:0]       ha_array_1_t,
    input  logic [6:0]       ha_array_2_b,
    input  logic [8:0]       ha_array_2_t,
    input  logic [6:0]       ha_array_3_b,
    input  logic [8:0]       ha_array_3_t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      product,
    output logic             ovf,
    output logic [CNT_W-1:0] txn_cnt
);

    // Row value: sums at their own weight, carries one column pair up (x4).
    function automatic logic [9:0] row_value(input logic [6:0] b, input logic [8:0] t);
        return {1'b0, t} + {1'b0, b, 2'b00};
    endfunction

    logic        s1_valid;
    logic        s2_valid;
    logic [12:0] p0;
    logic [12:0] p1;

    logic        s2_load;
    logic        accept;

    logic [9:0]  r0, r1, r2, r3;
    logic [12:0] p0_next;
    logic [12:0] p1_next;
    logic [16:0] sum_full;
    logic [15:0] product_next;

    assign r0 = row_value(ha_array_0_b, ha_array_0_t);
    assign r1 = row_value(ha_array_1_b, ha_array_1_t);
    assign r2 = row_value(ha_array_2_b, ha_array_2_t);
    assign r3 = row_value(ha_array_3_b, ha_array_3_t);

    assign p0_next = {3'b000, r0} + {1'b0, r1, 2'b00};
    assign p1_next = {3'b000, r2} + {1'b0, r3, 2'b00};

    // Worst case (every bit of every array set) reaches 86615, so bit 16 is
    // reachable with pruned/approximate generators and must be kept.
    assign sum_full = {4'b0000, p0} + {p1, 4'b0000};

    assign product_next = ((SATURATE != 0) && sum_full[16]) ? 16'hFFFF : sum_full[15:0];

    // s2 takes new data when empty or when its current result is consumed;
    // s1 can then always pass its contents on, so in_ready depends only on
    // out_ready and pipeline state, never on in_valid.
    assign s2_load  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign accept   = in_valid && in_ready;

    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            p0       <= '0;
            p1       <= '0;
            product  <= '0;
            ovf      <= 1'b0;
            txn_cnt  <= '0;
        end else begin
            if (accept) begin
                p0      <= p0_next;
                p1      <= p1_next;
                txn_cnt <= txn_cnt + CNT_W'(1);
            end
            // When in_ready is high, s1 is either empty or handing off to s2,
            // so its new occupancy is simply whether something arrives.
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    product <= product_next;
                    ovf     <= sum_full[16];
                end
            end
        end
    end

endmodule

// File: tb/tb_ha_array_reduce_8x8.sv
module tb_ha_array_reduce_8x8;

    typedef struct packed {
        logic [3:0][6:0] b;
        logic [3:0][8:0] t;
        logic [15:0]     p_trunc;
        logic [15:0]     p_sat;
        logic            ovf;
    } vec_t;

    typedef struct packed {
        logic [15:0] p_trunc;
        logic [15:0] p_sat;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [3:0][6:0] b_in;
    logic [3:0][8:0] t_in;

    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [15:0] product0, product1;
    logic        ovf0, ovf1;
    logic [15:0] txn_cnt0;
    logic [2:0]  txn_cnt1;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int exp_cnt = 0;
    bit lat_chk = 0;
    bit seen_stall = 0;
    bit hold_prev = 0;
    logic [15:0] hold_prod;
    vec_t pend;
    exp_t q[$];
    vec_t tbl[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ha_array_reduce_8x8 #(.SATURATE(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .ha_array_0_b(b_in[0]), .ha_array_0_t(t_in[0]),
        .ha_array_1_b(b_in[1]), .ha_array_1_t(t_in[1]),
        .ha_array_2_b(b_in[2]), .ha_array_2_t(t_in[2]),
        .ha_array_3_b(b_in[3]), .ha_array_3_t(t_in[3]),
        .out_valid(out_valid0), .out_ready(out_ready),
        .product(product0), .ovf(ovf0), .txn_cnt(txn_cnt0)
    );

    ha_array_reduce_8x8 #(.SATURATE(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .ha_array_0_b(b_in[0]), .ha_array_0_t(t_in[0]),
        .ha_array_1_b(b_in[1]), .ha_array_1_t(t_in[1]),
        .ha_array_2_b(b_in[2]), .ha_array_2_t(t_in[2]),
        .ha_array_3_b(b_in[3]), .ha_array_3_t(t_in[3]),
        .out_valid(out_valid1), .out_ready(out_ready),
        .product(product1), .ovf(ovf1), .txn_cnt(txn_cnt1)
    );

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Arrays as an exact generator would present them: row pair k holds
    // x * y[2k+1:2k], split into a carry part (b) and a sum part (t).
    function automatic vec_t gen(input int x, input int y);
        vec_t v;
        int   pp;
        for (int k = 0; k < 4; k++) begin
            pp = x * ((y >> (2 * k)) & 3);
            v.b[k] = 7'(pp >> 3);
            v.t[k] = 9'(pp - 4 * (pp >> 3));
        end
        v.p_trunc = 16'(x * y);
        v.p_sat   = 16'(x * y);
        v.ovf     = 1'b0;
        return v;
    endfunction

    function automatic vec_t raw(input logic [27:0] b, input logic [35:0] t,
                                 input logic [15:0] pt, input logic [15:0] ps, input logic o);
        vec_t v;
        v.b = b; v.t = t; v.p_trunc = pt; v.p_sat = ps; v.ovf = o;
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input vec_t v);
        bit ok;
        ok = 0;
        pend = v;
        b_in = v.b;
        t_in = v.t;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready0) begin
                ok = 1;
                break;
            end
        end
        chk(ok, "send_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk(ok, "drain_timeout", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard / protocol monitor, sampling mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            exp_cnt   = 0;
            hold_prev = 0;
        end else begin
            chk(txn_cnt0 == 16'(exp_cnt), "txn_cnt", 32'(txn_cnt0), 32'(16'(exp_cnt)));
            chk(txn_cnt1 == 3'(exp_cnt), "txn_cnt_wrap3", 32'(txn_cnt1), 32'(3'(exp_cnt)));
            chk(in_ready0 == ((q.size() < 2) || out_ready), "in_ready",
                32'(in_ready0), 32'((q.size() < 2) || out_ready));
            if (!in_ready0) seen_stall = 1;
            if (out_valid1 != out_valid0)
                chk(0, "out_valid_sat_inst", 32'(out_valid1), 32'(out_valid0));
            if (hold_prev) begin
                chk(out_valid0 && (product0 == hold_prod), "stall_hold",
                    {15'd0, out_valid0, product0}, {15'd0, 1'b1, hold_prod});
            end
            if (out_valid0) begin
                if (q.size() == 0) begin
                    chk(0, "stale_output", 32'(product0), 32'd0);
                end else if (out_ready) begin
                    e = q.pop_front();
                    chk(product0 == e.p_trunc, "product_trunc", 32'(product0), 32'(e.p_trunc));
                    chk(ovf0 == e.ovf, "ovf_trunc", 32'(ovf0), 32'(e.ovf));
                    chk(product1 == e.p_sat, "product_sat", 32'(product1), 32'(e.p_sat));
                    chk(ovf1 == e.ovf, "ovf_sat", 32'(ovf1), 32'(e.ovf));
                    if (lat_chk)
                        chk((cyc - e.cyc) == 2, "latency", 32'(cyc - e.cyc), 32'd2);
                end
            end
            if (in_valid && in_ready0) begin
                e.p_trunc = pend.p_trunc;
                e.p_sat   = pend.p_sat;
                e.ovf     = pend.ovf;
                e.cyc     = cyc;
                q.push_back(e);
                exp_cnt++;
            end
            hold_prev = out_valid0 && !out_ready;
            hold_prod = product0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = raw(28'd0, 36'h000000001, 16'h0001, 16'h0001, 1'b0);
        tbl[1] = raw({7'h40, 21'd0}, 36'd0, 16'h4000, 16'h4000, 1'b0);
        tbl[2] = gen(255, 255);
        tbl[2].p_trunc = 16'hFE01; tbl[2].p_sat = 16'hFE01;
        tbl[3] = gen(200, 131);
        tbl[3].p_trunc = 16'd26200; tbl[3].p_sat = 16'd26200;
        tbl[4] = raw({4{7'h7F}}, {4{9'h1FF}}, 16'h5257, 16'hFFFF, 1'b1);
        tbl[5] = raw(28'd0, {9'd0, 9'h1FF, 18'd0}, 16'h1FF0, 16'h1FF0, 1'b0);
        tbl[6] = raw({21'd0, 7'h7F}, 36'd0, 16'h01FC, 16'h01FC, 1'b0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; b_in = '0; t_in = '0;
        pend = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(out_valid0 == 1'b0, "reset_out_valid", 32'(out_valid0), 32'd0);
        chk(product0 == 16'd0, "reset_product", 32'(product0), 32'd0);
        chk(ovf0 == 1'b0, "reset_ovf", 32'(ovf0), 32'd0);
        chk(txn_cnt0 == 16'd0, "reset_txn_cnt", 32'(txn_cnt0), 32'd0);
        chk(in_ready0 == 1'b1, "reset_in_ready", 32'(in_ready0), 32'd1);
        @(posedge clk);
        #1;

        // Table vectors, isolated then back-to-back, no backpressure.
        lat_chk = 1;
        for (int i = 0; i < 7; i++) begin
            send(tbl[i]);
            drain();
        end
        for (int i = 0; i < 7; i++) send(tbl[i]);
        drain();
        lat_chk = 0;

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        send(gen(17, 99));
        send(gen(250, 3));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(out_valid0 == 1'b0, "rst_mid_out_valid", 32'(out_valid0), 32'd0);
        chk(txn_cnt0 == 16'd0, "rst_mid_txn_cnt", 32'(txn_cnt0), 32'd0);
        chk(in_ready0 == 1'b1, "rst_mid_in_ready", 32'(in_ready0), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(gen(12, 34));
        drain();

        // Stream of 8 with a 3-cycle output stall after the second accept.
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen_stall = 0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(gen(int'($urandom_range(0, 255)), int'($urandom_range(0, 255))));
            end
            begin
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (exp_cnt >= 2) break;
                end
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk(seen_stall == 1'b1, "stream_in_ready_fell", 32'(seen_stall), 32'd1);
        @(negedge clk);
        chk(txn_cnt0 == 16'd8, "stream_txn_cnt", 32'(txn_cnt0), 32'd8);
        chk(txn_cnt1 == 3'd0, "stream_txn_cnt_wrap", 32'(txn_cnt1), 32'd0);
        chk(q.size() == 0, "stream_queue_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
